// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer.
// A single 1-bit full-adder cell is fed one operand bit pair per clock,
// LSB first, with the carry recirculated through a flip-flop. Subtraction
// is a + ~b + 1: B is inverted at capture and the carry FF is preset to 1.
// Results (sum, carry-out, signed overflow) are published on the edge that
// processes the MSB and are held until the next completion.

// One-bit full-adder cell: the only arithmetic element in the datapath.
module serial_adder_ctrl_fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    // Counter just wide enough to index every bit position once.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Control state
    state_t           state_q;
    state_t           state_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;

    // Datapath state
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] a_sh_d;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] b_sh_d;
    logic [WIDTH-1:0] res_sh_q;
    logic [WIDTH-1:0] res_sh_d;
    logic             carry_q;
    logic             carry_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Published results
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             cout_q;
    logic             cout_d;
    logic             ovf_q;
    logic             ovf_d;

    // Helper nets
    logic [WIDTH-1:0] b_load;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic [WIDTH-1:0] res_next;
    logic             fa_sum;
    logic             fa_carry;
    logic             accept;
    logic             last_bit;

    assign accept   = (state_q == ST_IDLE) && start_i;
    assign last_bit = (state_q == ST_RUN) && (cnt_q == CNT_LAST);

    // Per-bit operand conditioning and right-shift wiring.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bits
            // Subtraction uses the one's complement of B; the +1 comes from the carry preset.
            assign b_load[gi] = b_i[gi] ^ sub_i;

            if (gi == WIDTH - 1) begin : g_top
                // Zero fill at the MSB end; these bits are never consumed.
                assign a_shift[gi]  = 1'b0;
                assign b_shift[gi]  = 1'b0;
                // The fresh sum bit enters the result register at the MSB end.
                assign res_next[gi] = fa_sum;
            end else begin : g_low
                assign a_shift[gi]  = a_sh_q[gi+1];
                assign b_shift[gi]  = b_sh_q[gi+1];
                assign res_next[gi] = res_sh_q[gi+1];
            end
        end
    endgenerate

    // The shared adder cell always sees the current LSBs and the carry FF.
    serial_adder_ctrl_fa_cell u_fa (
        .a_i (a_sh_q[0]),
        .b_i (b_sh_q[0]),
        .c_i (carry_q),
        .s_o (fa_sum),
        .c_o (fa_carry)
    );

    // State register plus registered status flags (async reset to IDLE).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: start is honoured only in IDLE; DONE always lasts one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so busy/done come straight from flops.
    always_comb begin
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // Datapath next values: capture on accept, shift one bit per RUN cycle,
    // publish results on the MSB edge.
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        if (accept) begin
            a_sh_d  = a_i;
            b_sh_d  = b_load;
            carry_d = sub_i;
            cnt_d   = '0;
        end else if (state_q == ST_RUN) begin
            a_sh_d   = a_shift;
            b_sh_d   = b_shift;
            res_sh_d = res_next;
            carry_d  = fa_carry;
            if (last_bit) begin
                // carry_q is the carry into the MSB at this point; compare it
                // with the carry out of the MSB for signed overflow.
                cnt_d  = '0;
                sum_d  = res_next;
                cout_d = fa_carry;
                ovf_d  = carry_q ^ fa_carry;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Datapath and result registers (async reset clears everything).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl (WIDTH=8): table of directed add/subtract
// vectors plus sequences for operand changes, ignored starts, async reset
// mid-operation and back-to-back operation with start held high.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk_i;
    logic             rst_i;
    logic             start_i;
    logic             sub_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;
    logic             ovf_o;

    int n_compared;
    int n_mismatched;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs [8];

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .sub_i   (sub_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .sum_o   (sum_o),
        .cout_o  (cout_o),
        .ovf_o   (ovf_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Runs one operation. With pre_driven=1 the caller already raised start_i
    // at the current negedge; otherwise the task drives it at the next one.
    task automatic run_vec(input vec_t v, input int idx, input bit pre_driven);
        int busy_cnt;
        bit seen;
        if (!pre_driven) begin
            @(negedge clk_i);
            a_i     = v.a;
            b_i     = v.b;
            sub_i   = v.sub;
            start_i = 1'b1;
        end
        @(negedge clk_i);
        start_i  = 1'b0;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int cyc = 0; cyc < 4 * WIDTH && !seen; cyc++) begin
            if (done_o) begin
                seen = 1'b1;
            end else begin
                if (busy_o) busy_cnt++;
                @(negedge clk_i);
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("busy_cycles", 32'(busy_cnt), 32'(WIDTH));
        check("busy_low_at_done", 32'(busy_o), 32'd0);
        check("sum", 32'(sum_o), 32'(v.sum));
        check("cout", 32'(cout_o), 32'(v.cout));
        check("ovf", 32'(ovf_o), 32'(v.ovf));
        $display("op %0d: a=%02h b=%02h sub=%0d -> sum=%02h cout=%0d ovf=%0d (want %02h %0d %0d)",
                 idx, v.a, v.b, v.sub, sum_o, cout_o, ovf_o, v.sum, v.cout, v.ovf);
        @(negedge clk_i);
        check("done_one_cycle", 32'(done_o), 32'd0);
        check("sum_held", 32'(sum_o), 32'(v.sum));
    endtask

    initial begin
        int   done_cnt;
        int   pulse_t [4];
        int   n_pulses;
        bit   seen;
        vec_t v;

        n_compared   = 0;
        n_mismatched = 0;

        //            a      b      sub   sum    cout  ovf
        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{8'hC8, 8'h9C, 1'b0, 8'h64, 1'b1, 1'b1};
        vecs[6] = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0};

        rst_i   = 1'b1;
        start_i = 1'b0;
        sub_i   = 1'b0;
        a_i     = '0;
        b_i     = '0;

        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_sum", 32'(sum_o), 32'd0);
        check("rst_cout", 32'(cout_o), 32'd0);
        check("rst_ovf", 32'(ovf_o), 32'd0);
        rst_i = 1'b0;

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i, 1'b0);
        end

        // Operand churn and a start pulse during RUN: exactly one result, 0x03
        @(negedge clk_i);
        a_i = 8'h01; b_i = 8'h02; sub_i = 1'b0; start_i = 1'b1;
        @(negedge clk_i);
        start_i  = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            if (done_o) begin
                done_cnt++;
                check("churn_sum", 32'(sum_o), 32'h03);
            end
            if (c == 2) begin
                start_i = 1'b1;
                a_i     = 8'h77;
            end else begin
                start_i = 1'b0;
                if (c < 10) begin
                    a_i   = 8'($urandom);
                    b_i   = 8'($urandom);
                    sub_i = 1'($urandom);
                end
            end
            @(negedge clk_i);
        end
        check("churn_done_count", 32'(done_cnt), 32'd1);
        check("churn_busy_idle", 32'(busy_o), 32'd0);
        $display("churn op: a=01 b=02 -> sum=%02h, done pulses=%0d", sum_o, done_cnt);

        // Previous result stays visible during a new RUN; start in DONE is ignored
        a_i = 8'h10; b_i = 8'h10; sub_i = 1'b0; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("hold_busy_mid_run", 32'(busy_o), 32'd1);
        check("hold_sum_mid_run", 32'(sum_o), 32'h03);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (done_o) seen = 1'b1;
            else @(negedge clk_i);
        end
        check("hold_done_seen", 32'(seen), 32'd1);
        check("hold_new_sum", 32'(sum_o), 32'h20);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        check("start_in_done_ignored", 32'(busy_o), 32'd0);
        $display("hold op: a=10 b=10 -> sum=%02h, busy after DONE-start=%0d", sum_o, busy_o);

        // Asynchronous reset mid-RUN
        @(negedge clk_i);
        a_i = 8'h5A; b_i = 8'h3C; sub_i = 1'b0; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy_o), 32'd0);
        check("async_rst_done", 32'(done_o), 32'd0);
        check("async_rst_sum", 32'(sum_o), 32'd0);
        check("async_rst_cout", 32'(cout_o), 32'd0);
        check("async_rst_ovf", 32'(ovf_o), 32'd0);
        $display("async reset mid-RUN: busy=%0d done=%0d sum=%02h", busy_o, done_o, sum_o);
        repeat (2) @(negedge clk_i);
        // Release and request in the same cycle: accepted on the first edge
        rst_i   = 1'b0;
        v       = '{8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0, 1'b1};
        a_i     = v.a;
        b_i     = v.b;
        sub_i   = v.sub;
        start_i = 1'b1;
        run_vec(v, 100, 1'b1);

        // Start held high: done pulses every WIDTH+2 cycles
        @(negedge clk_i);
        a_i = 8'h03; b_i = 8'h04; sub_i = 1'b0; start_i = 1'b1;
        n_pulses = 0;
        for (int t = 0; t < 50 && n_pulses < 4; t++) begin
            @(negedge clk_i);
            if (done_o) begin
                pulse_t[n_pulses] = t;
                n_pulses++;
            end
        end
        start_i = 1'b0;
        check("b2b_pulse_count", 32'(n_pulses), 32'd4);
        check("b2b_sum", 32'(sum_o), 32'h07);
        for (int p = 1; p < 4; p++) begin
            if (p < n_pulses) begin
                check("b2b_interval", 32'(pulse_t[p] - pulse_t[p-1]), 32'(WIDTH + 2));
                $display("b2b pulse %0d: interval %0d cycles", p, pulse_t[p] - pulse_t[p-1]);
            end
        end
        repeat (WIDTH + 4) @(negedge clk_i);
        check("b2b_idle_after", 32'(busy_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial add/subtract sequencer built around a single 1-bit full-adder cell (sum = a^b^c, carry = majority). It captures two WIDTH-bit operands on a start request and feeds the cell one bit pair per clock, LSB first, recirculating the carry through a flip-flop. It returns the WIDTH-bit result with carry-out and signed overflow. It sits between a requester (FSM or testbench driver) and the adder datapath, trading latency for area.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  operation request; sampled only in IDLE.
- sub_i  input  1  0 = a+b, 1 = a-b; sampled with start_i.
- a_i  input  WIDTH  operand A, captured on accepted start.
- b_i  input  WIDTH  operand B, captured on accepted start.
- busy_o  output  1  high while in RUN.
- done_o  output  1  one-cycle completion pulse (state DONE).
- sum_o  output  WIDTH  result; held until the next completion.
- cout_o  output  1  carry out of MSB; for subtract, 1 = no borrow (a ≥ b unsigned).
- ovf_o  output  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-high, on clk_i / rst_i.
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: busy_o=0, done_o=0, sum_o=0, cout_o=0, ovf_o=0. Internal shift registers, counter and carry FF are cleared.
- IDLE, start_i=1:
  - Load shift register A ← a_i.
  - Load shift register B ← (sub_i ? ~b_i : b_i).
  - Carry FF ← sub_i. Bit counter ← 0. Next state RUN.
- IDLE, start_i=0: remain in IDLE.
- Each RUN cycle:
  - Full-adder inputs are A[0], B[0], carry FF.
  - Sum bit shifts into the result shift register from the MSB end.
  - A and B shift right by one. Carry FF ← cell carry. Counter increments.
  - When counter = WIDTH-1, record the carry-in of this bit (for ovf).
- RUN, counter = WIDTH-1: this edge processes the MSB and transfers the results to sum_o/cout_o/ovf_o. Next state DONE.
- DONE: done_o=1 for exactly one cycle. Next state IDLE unconditionally.
- start_i is ignored in RUN and DONE; it is not queued. Holding start_i high re-triggers in the first IDLE cycle.
- a_i, b_i and sub_i may change freely after capture without affecting the operation in progress.
- Arithmetic is modulo 2^WIDTH. Subtract is two's complement a + ~b + 1.
- sum_o, cout_o and ovf_o change only on the completion edge (and on reset). Previous results stay visible during a new RUN.
- Counter width is $clog2(WIDTH) bits; it never wraps within an operation.

## Timing
- start_i is accepted at edge k in IDLE. RUN covers edges k+1..k+WIDTH.
- Results are valid and done_o=1 from edge k+WIDTH to edge k+WIDTH+1. busy_o=1 from edge k to edge k+WIDTH.
- Earliest next accepted start is at edge k+WIDTH+2. Throughput is one operation per WIDTH+2 cycles.
- Reset asserted mid-RUN or in DONE:
  - Immediate (asynchronous) return to IDLE with all outputs at reset values.
  - No done_o pulse for the aborted operation.
  - First start is accepted on the first rising edge after rst_i deasserts.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, sub=0, start pulse at edge k → busy_o high for 8 cycles; done_o high for exactly one cycle after edge k+8; sum_o=0x96, cout_o=0, ovf_o=1.
- a=0xFF, b=0x01, sub=0 → sum_o=0x00, cout_o=1, ovf_o=0.
- a=0x10, b=0x20, sub=1 → sum_o=0xF0, cout_o=0, ovf_o=0. Then a=0x80, b=0x01, sub=1 → sum_o=0x7F, cout_o=1, ovf_o=1.
- Operand change and repeated start:
  - Start with a=0x01, b=0x02.
  - Pulse start_i again with a=0x77 at cycle 3 of RUN, and change a_i/b_i every cycle.
  - Required: result 0x03, exactly one done_o pulse, sum_o holds 0x03 until the next completion.
- Reset and back-to-back:
  - Assert rst_i asynchronously mid-RUN (between edges) → all outputs drop to 0 immediately; no done_o pulse.
  - After release, start a=0x7F, b=0x7F → sum_o=0xFE, ovf_o=1.
  - Hold start_i high continuously → done_o pulses every WIDTH+2 = 10 cycles.
